pwm_timer_array: RTL

- Memory-mapped, multi-channel timer/PWM peripheral on the same single-master bus the I2C controller uses: busAddr, busWr, busEn and 16-bit bidirectional busData.
- Generalises the fixed single-function peripheral into NUM_CH identical channels sharing one prescaler.
- Each channel has three modes: continuous PWM, periodic timer, one-shot.
- Drives PWM pins, sticky wrap flags and one maskable interrupt. Sits beside the I2C controller and is debuggable over the JTAG memory controller.

---
 rtl/pwm_timer_pkg.sv | 35 +++
 rtl/pwm_timer_array_channel.sv | 61 ++++++
 rtl/pwm_timer_array.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the multi-channel PWM/timer peripheral: register
// map indices, channel mode encoding and the per-channel config layout.
package pwm_timer_pkg;

  // Global register indices
  localparam int GCTRL_IDX  = 0;
  localparam int STATUS_IDX = 1;

  // Per-channel register block: CH_BASE + ch*CH_STRIDE + offset
  localparam int CH_BASE    = 2;
  localparam int CH_STRIDE  = 3;
  localparam int PERIOD_OFS = 0;
  localparam int DUTY_OFS   = 1;
  localparam int CFG_OFS    = 2;

  // Channel operating mode. Encoding 3 is reserved and treated as PWM.
  typedef enum logic [1:0] {
    PWM      = 2'd0,
    PERIODIC = 2'd1,
    ONESHOT  = 2'd2
  } mode_t;

  // CFGn register layout: [3] inv, [2:1] mode, [0] en
  typedef struct packed {
    logic  inv;
    mode_t mode;
    logic  en;
  } cfg_t;

  // Register index of a given channel's register
  function automatic int reg_idx(input int ch, input int ofs);
    return CH_BASE + ch * CH_STRIDE + ofs;
  endfunction

endpackage

// File: rtl/pwm_timer_array_channel.sv
// One timer/PWM channel: counter with >= period wrap, duty compare,
// one-shot self-disable request and a registered output pin.
module pwm_channel
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  cfg_t             cfg,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic             en_rise,
  output logic             wrap,
  output logic             pwm_out,
  output logic             en_clear
);

  logic [CNT_W-1:0] count_q;
  logic             raw;
  logic             event_mode;

  // Wrap detection, raw output selection and one-shot disable request
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    wrap       = 1'b0;
    event_mode = 1'b0;
    raw        = 1'b0;
    en_clear   = 1'b0;
    // >= (not ==) so a period shrunk below the current count wraps at once
    wrap       = tick && cfg.en && (count_q >= period);
    event_mode = (cfg.mode == PERIODIC) || (cfg.mode == ONESHOT);
    raw        = event_mode ? wrap : (count_q < duty);
    en_clear   = wrap && (cfg.mode == ONESHOT);
  end

  // Counter: cleared on enable rising, advances on tick while enabled
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      count_q <= '0;
    end else if (en_rise) begin
      count_q <= '0;
    end else if (tick && cfg.en) begin
      count_q <= wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  // Registered output pin; gated by enable, then optionally inverted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cfg.en & raw) ^ cfg.inv;
    end
  end

endmodule

// File: rtl/pwm_timer_array.sv
// Memory-mapped multi-channel PWM/timer peripheral. Owns the bus decode,
// the shared prescaler, the sticky wrap flags with W1C, the interrupt and
// the tri-state read data; the channels do the counting.
module pwm_timer_array
  import pwm_timer_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int ADDR_W = $clog2(2 + 3 * NUM_CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] busAddr,
  input  logic              busWr,
  input  logic              busEn,
  inout  wire  [15:0]       busData,
  output logic [NUM_CH-1:0] pwmOut,
  output logic              irq
);

  logic              wr_en;
  logic              rd_en;
  logic              gctrl_wr;
  logic [NUM_CH-1:0] w1c;
  logic [15:0]       rd_data;

  logic [7:0]        presc_q;
  logic [7:0]        irq_mask_q;
  logic [7:0]        presc_cnt_q;
  logic              tick;

  logic [NUM_CH-1:0] status_q;
  logic              irq_q;

  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  cfg_t              cfg_q    [NUM_CH];

  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] en_rise;
  logic [NUM_CH-1:0] en_clear;
  logic [NUM_CH-1:0] pwm_bit;

  // Bus write decode shared by the register file and the channels
  always_comb begin
    wr_en    = busEn & busWr;
    rd_en    = busEn & ~busWr;
    gctrl_wr = wr_en && (int'(busAddr) == GCTRL_IDX);
    w1c      = (wr_en && (int'(busAddr) == STATUS_IDX)) ? busData[NUM_CH-1:0] : '0;
    en_rise  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      en_rise[ch] = wr_en && (int'(busAddr) == reg_idx(ch, CFG_OFS)) &&
                    busData[0] && !cfg_q[ch].en;
    end
  end

  // Prescaler: down-counter, tick when it reaches zero, reload on GCTRL write
  assign tick = (presc_cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_cnt_q <= '0;
    end else if (gctrl_wr) begin
      presc_cnt_q <= busData[7:0];
    end else if (tick) begin
      presc_cnt_q <= presc_q;
    end else begin
      presc_cnt_q <= presc_cnt_q - 8'd1;
    end
  end

  // Register file, sticky flags (set wins over W1C) and registered irq
  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_q    <= '0;
      irq_mask_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      // NOTE: the per-channel register arrays are real flops that must all
      // clear on reset, so they are reset element by element here.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        period_q[ch] <= '0;
        duty_q[ch]   <= '0;
        cfg_q[ch]    <= '0;
      end
    end else begin
      if (gctrl_wr) begin
        {irq_mask_q, presc_q} <= busData;
      end
      status_q <= (status_q & ~w1c) | wrap;
      irq_q    <= |(status_q & irq_mask_q[NUM_CH-1:0]);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_en && (int'(busAddr) == reg_idx(ch, PERIOD_OFS))) begin
          period_q[ch] <= busData[CNT_W-1:0];
        end
        if (wr_en && (int'(busAddr) == reg_idx(ch, DUTY_OFS))) begin
          duty_q[ch] <= busData[CNT_W-1:0];
        end
        if (wr_en && (int'(busAddr) == reg_idx(ch, CFG_OFS))) begin
          cfg_q[ch] <= cfg_t'(busData[3:0]);
        end
        // One-shot completion overrides any EN written on the same edge
        if (en_clear[ch]) begin
          cfg_q[ch].en <= 1'b0;
        end
      end
    end
  end

  // Combinational read mux; narrower registers are zero-extended
  always_comb begin
    rd_data = '0;
    if (int'(busAddr) == GCTRL_IDX) begin
      rd_data = {irq_mask_q, presc_q};
    end else if (int'(busAddr) == STATUS_IDX) begin
      rd_data[NUM_CH-1:0] = status_q;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (int'(busAddr) == reg_idx(ch, PERIOD_OFS)) rd_data[CNT_W-1:0] = period_q[ch];
        if (int'(busAddr) == reg_idx(ch, DUTY_OFS))   rd_data[CNT_W-1:0] = duty_q[ch];
        if (int'(busAddr) == reg_idx(ch, CFG_OFS))    rd_data[3:0]       = cfg_q[ch];
      end
    end
  end

  assign busData = rd_en ? rd_data : 16'hzzzz;
  assign pwmOut  = pwm_bit;
  assign irq     = irq_q;

  // One channel instance per timer
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .tick    (tick),
      .cfg     (cfg_q[ch]),
      .period  (period_q[ch]),
      .duty    (duty_q[ch]),
      .en_rise (en_rise[ch]),
      .wrap    (wrap[ch]),
      .pwm_out (pwm_bit[ch]),
      .en_clear(en_clear[ch])
    );
  end

endmodule
